// File: rtl/sme_dom_and_ctrl.sv
// sme_dom_and_ctrl: round-robin arbiter and sequencer that shares one masked
// DOM-AND gadget between NREQ requesters, one operation in flight at a time.
// Ports:
//   g_clk, g_reset        clock, asynchronous active-high reset
//   req_valid/req_ready   per-requester request, one-hot accept pulse
//   rng_valid/rng_ready   fresh randomness word / consume pulse
//   and_en                one-cycle gadget enable
//   sel                   operand-mux select, held from GRANT through RESP
//   rsp_valid/rsp_id      gadget result valid for requester rsp_id
//   rsp_ready             response accepted
//   busy                  high whenever an operation is in flight
module sme_dom_and_ctrl #(
   parameter int NREQ = 2,
   parameter int LAT  = 1,
   parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic            g_clk,
   input  logic            g_reset,
   input  logic [NREQ-1:0] req_valid,
   output logic [NREQ-1:0] req_ready,
   input  logic            rng_valid,
   output logic            rng_ready,
   output logic            and_en,
   output logic [IDW-1:0]  sel,
   output logic            rsp_valid,
   output logic [IDW-1:0]  rsp_id,
   input  logic            rsp_ready,
   output logic            busy
);

   localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
   localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

   typedef enum logic [2:0] {
      S_IDLE,
      S_GRANT,
      S_WAITR,
      S_FIRE,
      S_HOLD,
      S_RESP
   } state_t;

   state_t         state;
   state_t         state_nxt;
   logic [IDW-1:0] ptr;
   logic [IDW-1:0] ptr_nxt;
   logic [CW-1:0]  cnt;
   logic           pick_hit;
   logic [IDW-1:0] pick_idx;

   // First requester at or after ptr, cyclically. Walking downwards lets
   // the lowest rotated offset win.
   always_comb begin
      logic [IDW:0] idx;
      pick_hit = 1'b0;
      pick_idx = '0;
      idx      = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         idx = {1'b0, ptr} + (IDW+1)'(i);
         if (idx >= NREQ_W)
            idx = idx - NREQ_W;
         if (req_valid[idx[IDW-1:0]]) begin
            pick_hit = 1'b1;
            pick_idx = idx[IDW-1:0];
         end
      end
   end

   assign ptr_nxt = (sel == IDW'(NREQ - 1)) ? '0 : sel + 1'b1;

   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset) begin
         ptr <= '0;
         sel <= '0;
         cnt <= '0;
      end else begin
         if (state == S_IDLE && pick_hit)
            sel <= pick_idx;
         if (state == S_FIRE)
            cnt <= CW'(LAT - 1);
         else if (state == S_HOLD)
            cnt <= cnt - 1'b1;
         if (state == S_RESP && rsp_ready)
            ptr <= ptr_nxt;
      end
   end

   // HOLD leaves on the cycle its count steps to zero, which puts
   // rsp_valid exactly LAT cycles after and_en.
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:  if (pick_hit) state_nxt = S_GRANT;
         S_GRANT: state_nxt = S_WAITR;
         S_WAITR: if (rng_valid) state_nxt = S_FIRE;
         S_FIRE:  state_nxt = (LAT == 1) ? S_RESP : S_HOLD;
         S_HOLD:  if (cnt == CW'(1)) state_nxt = S_RESP;
         S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready = '0;
      and_en    = 1'b0;
      rng_ready = 1'b0;
      rsp_valid = 1'b0;
      rsp_id    = '0;
      busy      = (state != S_IDLE);
      unique case (state)
         S_IDLE: begin
            if (pick_hit)
               req_ready = NREQ'(1) << pick_idx;
         end
         S_FIRE: begin
            and_en    = 1'b1;
            rng_ready = 1'b1;
         end
         S_RESP: begin
            rsp_valid = 1'b1;
            rsp_id    = sel;
         end
         default: ;
      endcase
   end

   always_ff @(posedge g_clk) begin
      if (!g_reset)
         assert (32'(sel) < 32'(NREQ));
   end

endmodule

// File: tb/tb_sme_dom_and_ctrl.sv
// tb_sme_dom_and_ctrl: directed and randomized operations against two
// configurations (NREQ=2/LAT=1 and NREQ=4/LAT=3) with a transaction model.
module tb_sme_dom_and_ctrl;

   logic       clk;
   logic       g_reset;
   logic [7:0] req;
   logic       rng_valid;
   logic       rsp_ready;
   int         inst;

   logic [1:0] req_a;
   logic [1:0] rr_a;
   logic       rngr_a, en_a, rv_a, busy_a;
   logic       sel_a, id_a;

   logic [3:0] req_b;
   logic [3:0] rr_b;
   logic       rngr_b, en_b, rv_b, busy_b;
   logic [1:0] sel_b, id_b;

   logic [7:0] o_rr;
   logic       o_rngr, o_en, o_rv, o_busy;
   logic [7:0] o_sel, o_id;

   int n_checks;
   int n_pass;
   int ptr_m;
   int sel_m;

   assign req_a = (inst == 0) ? req[1:0] : 2'b0;
   assign req_b = (inst == 1) ? req[3:0] : 4'b0;

   sme_dom_and_ctrl #(.NREQ(2), .LAT(1)) u_a (
      .g_clk(clk), .g_reset(g_reset),
      .req_valid(req_a), .req_ready(rr_a),
      .rng_valid(rng_valid), .rng_ready(rngr_a),
      .and_en(en_a), .sel(sel_a),
      .rsp_valid(rv_a), .rsp_id(id_a),
      .rsp_ready(rsp_ready), .busy(busy_a)
   );

   sme_dom_and_ctrl #(.NREQ(4), .LAT(3)) u_b (
      .g_clk(clk), .g_reset(g_reset),
      .req_valid(req_b), .req_ready(rr_b),
      .rng_valid(rng_valid), .rng_ready(rngr_b),
      .and_en(en_b), .sel(sel_b),
      .rsp_valid(rv_b), .rsp_id(id_b),
      .rsp_ready(rsp_ready), .busy(busy_b)
   );

   always_comb begin
      if (inst == 0) begin
         o_rr   = {6'b0, rr_a};
         o_rngr = rngr_a;
         o_en   = en_a;
         o_rv   = rv_a;
         o_busy = busy_a;
         o_sel  = {7'b0, sel_a};
         o_id   = {7'b0, id_a};
      end else begin
         o_rr   = {4'b0, rr_b};
         o_rngr = rngr_b;
         o_en   = en_b;
         o_rv   = rv_b;
         o_busy = busy_b;
         o_sel  = {6'b0, sel_b};
         o_id   = {6'b0, id_b};
      end
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] o,
                        input logic [31:0] e);
      n_checks++;
      assert (o === e) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
   endtask

   task automatic expect_outs(input string tag, input logic [7:0] rr,
                              input bit en, input bit rv, input bit bz,
                              input int s);
      check({tag, ".req_ready"}, 32'(o_rr), 32'(rr));
      check({tag, ".and_en"}, 32'(o_en), 32'(en));
      check({tag, ".rng_ready"}, 32'(o_rngr), 32'(en));
      check({tag, ".rsp_valid"}, 32'(o_rv), 32'(rv));
      check({tag, ".busy"}, 32'(o_busy), 32'(bz));
      check({tag, ".sel"}, 32'(o_sel), 32'(s));
      if (rv)
         check({tag, ".rsp_id"}, 32'(o_id), 32'(s));
   endtask

   // One full operation: accept, grant, rng stall, fire, gadget latency,
   // response backpressure. Expected timing comes from the protocol rules.
   task automatic do_op(input logic [7:0] reqv, input int stall,
                        input int bp, input int rst_at, input bit hold);
      int n, lat, g, fire, rr_c, idx;
      bit found;
      logic [7:0] rr_e;
      string tag;
      n     = (inst == 0) ? 2 : 4;
      lat   = (inst == 0) ? 1 : 3;
      reqv  = reqv & 8'((1 << n) - 1);
      g     = 0;
      found = 0;
      for (int i = 0; i < n; i++) begin
         idx = (ptr_m + i) % n;
         if (!found && reqv[idx]) begin
            g     = idx;
            found = 1;
         end
      end
      fire = 3 + stall;
      rr_c = fire + lat + bp;
      for (int c = 0; c <= rr_c; c++) begin
         @(negedge clk);
         req = (c == 0 || hold) ? reqv : 8'h00;
         if (c == 0)
            rng_valid = 1'($urandom_range(0, 1));
         else if (c < fire)
            rng_valid = (c >= 2 + stall);
         else
            rng_valid = 1'($urandom_range(0, 1));
         if (c == rr_c)
            rsp_ready = 1'b1;
         else if (c < fire + lat)
            rsp_ready = 1'($urandom_range(0, 1));
         else
            rsp_ready = 1'b0;
         #1;
         tag  = $sformatf("i%0d.g%0d.c%0d", inst, g, c);
         rr_e = (c == 0) ? 8'(1 << g) : 8'h00;
         expect_outs(tag, rr_e, c == fire, c >= fire + lat, c > 0,
                     (c == 0) ? sel_m : g);
         sel_m = g;
         if (c == rst_at) begin
            req     = 8'h00;
            g_reset = 1'b1;
            #1;
            expect_outs("rst.async", 8'h00, 0, 0, 0, 0);
            @(negedge clk);
            expect_outs("rst.held", 8'h00, 0, 0, 0, 0);
            g_reset = 1'b0;
            ptr_m   = 0;
            sel_m   = 0;
            return;
         end
      end
      ptr_m = (g + 1) % n;
   endtask

   task automatic rand_ops(input int cnt);
      int n;
      n = (inst == 0) ? 2 : 4;
      for (int k = 0; k < cnt; k++)
         do_op(8'($urandom_range(1, (1 << n) - 1)),
               int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
               -1, 1'($urandom_range(0, 1)));
   endtask

   initial begin
      n_checks  = 0;
      n_pass    = 0;
      ptr_m     = 0;
      sel_m     = 0;
      inst      = 0;
      req       = 8'h00;
      rng_valid = 1'b0;
      rsp_ready = 1'b0;
      g_reset   = 1'b1;
      #3;
      expect_outs("reset.a", 8'h00, 0, 0, 0, 0);
      inst = 1;
      #1;
      expect_outs("reset.b", 8'h00, 0, 0, 0, 0);
      inst = 0;
      @(negedge clk);
      g_reset = 1'b0;

      // NREQ=2, LAT=1: single op, round-robin, rng stall, backpressure
      do_op(8'b01, 0, 0, -1, 0);
      for (int k = 0; k < 4; k++)
         do_op(8'b11, 0, 0, -1, 1);
      do_op(8'b10, 5, 0, -1, 0);
      do_op(8'b11, 0, 4, -1, 1);
      rand_ops(25);
      @(negedge clk);
      req   = 8'h00;
      ptr_m = 0;
      sel_m = 0;

      // NREQ=4, LAT=3
      inst = 1;
      do_op(8'b0001, 0, 0, -1, 0);
      do_op(8'b1000, 0, 0, -1, 0);
      do_op(8'b1111, 0, 0, -1, 0);
      do_op(8'b0110, 2, 1, -1, 1);
      rand_ops(25);
      do_op(8'b0010, 0, 0, -1, 0);
      do_op(8'b0100, 0, 0, 4, 1);
      do_op(8'b1111, 0, 0, -1, 0);
      rand_ops(10);
      @(negedge clk);
      req = 8'h00;
      #1;
      expect_outs("end.idle", 8'h00, 0, 0, 0, sel_m);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
